// File: rtl/eth_rx_sequencer.sv
// Receive sequencer: synchronizes the front end's sck/mosi/cs, finds the SFD and packs
// LSB-first bytes into a byte FIFO presented as a valid/ready stream plus a status word.
module eth_rx_sequencer #(
    parameter int DEPTH   = 2048,
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        sck,
    input  logic        mosi,
    input  logic        cs,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        st_valid,
    input  logic        st_ready,
    output logic [10:0] st_len,
    output logic [3:0]  st_flags,
    output logic [15:0] drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] SFD = 8'hD5;

    typedef enum logic [2:0] {IDLE, HUNT, DATA, DROP_HOLD, FLUSH, DROP} state_t;

    state_t      state;
    logic        sck_s1, sck_s2, sck_d;
    logic        mosi_s1, mosi_s2;
    logic        cs_s1, cs_s2, cs_d;
    logic [7:0]  sr;
    logic [2:0]  bit_cnt;
    logic [10:0] len;
    logic        hold_valid;
    logic [7:0]  hold_data;
    logic        align_err;
    logic        overflow;

    logic        bit_event, cs_rise, cs_fall;
    logic [7:0]  next_sr;
    logic [10:0] len_inc;

    logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic          full, rd_fire, space, wr_en;
    logic [8:0]    wr_data;
    logic [8:0]    mem [DEPTH];
    logic [8:0]    rd_q, byp_q;
    logic          byp_sel;

    assign bit_event = sck_s2 & ~sck_d;
    assign cs_rise   = cs_s2 & ~cs_d;
    assign cs_fall   = ~cs_s2 & cs_d;
    assign next_sr   = {mosi_s2, sr[7:1]};
    assign len_inc   = (len == 11'h7FF) ? len : len + 11'd1;

    // One slot stays free so the pointers alone tell full from empty.
    assign full    = (wr_ptr + AW'(1)) == rd_ptr;
    assign rd_fire = m_valid & m_ready;
    assign space   = ~full | rd_fire;

    always_comb begin
        wr_en   = 1'b0;
        wr_data = 9'h000;
        if (state == DATA && bit_event && bit_cnt == 3'd7 && hold_valid && space) begin
            wr_en   = 1'b1;
            wr_data = {1'b0, hold_data};
        end else if (state == FLUSH && hold_valid && space) begin
            wr_en   = 1'b1;
            wr_data = {1'b1, hold_data};
        end
    end

    assign wr_ptr_next = wr_ptr + AW'(wr_en);
    assign rd_ptr_next = rd_ptr + AW'(rd_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            m_valid <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_next;
            rd_ptr  <= rd_ptr_next;
            m_valid <= (wr_ptr_next != rd_ptr_next);
        end
    end

    // Registered RAM read of the next head; a write into an empty FIFO is forwarded.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
        rd_q    <= mem[rd_ptr_next];
        byp_sel <= wr_en && (wr_ptr == rd_ptr_next);
        byp_q   <= wr_data;
    end

    assign m_data = m_valid ? (byp_sel ? byp_q[7:0] : rd_q[7:0]) : 8'h00;
    assign m_last = m_valid ? (byp_sel ? byp_q[8]   : rd_q[8])   : 1'b0;

    // cs synchronizer resets high so a frame already in flight at reset is never mistaken for a start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_d <= 1'b0;
            mosi_s1 <= 1'b0; mosi_s2 <= 1'b0;
            cs_s1 <= 1'b1; cs_s2 <= 1'b1; cs_d <= 1'b1;
            state      <= IDLE;
            sr         <= 8'h00;
            bit_cnt    <= 3'd0;
            len        <= 11'd0;
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
            align_err  <= 1'b0;
            overflow   <= 1'b0;
            st_valid   <= 1'b0;
            st_len     <= 11'd0;
            st_flags   <= 4'h0;
            drop_cnt   <= 16'd0;
        end else begin
            sck_s1 <= sck;   sck_s2 <= sck_s1;   sck_d <= sck_s2;
            mosi_s1 <= mosi; mosi_s2 <= mosi_s1;
            cs_s1 <= cs;     cs_s2 <= cs_s1;     cs_d <= cs_s2;
            if (bit_event) sr <= next_sr;
            if (st_valid && st_ready) st_valid <= 1'b0;
            case (state)
                IDLE: if (cs_rise) state <= enable ? HUNT : DROP;
                HUNT: begin
                    if (cs_fall) begin
                        state <= IDLE;
                    end else if (bit_event && next_sr == SFD) begin
                        if (st_valid) begin
                            state    <= DROP;
                            drop_cnt <= drop_cnt + 16'd1;
                        end else begin
                            state      <= DATA;
                            bit_cnt    <= 3'd0;
                            len        <= 11'd0;
                            align_err  <= 1'b0;
                            overflow   <= 1'b0;
                            hold_valid <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (bit_event) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            len <= len_inc;
                            if (hold_valid && !space) begin
                                overflow <= 1'b1;
                                state    <= DROP_HOLD;
                            end else begin
                                hold_data  <= next_sr;
                                hold_valid <= 1'b1;
                            end
                        end
                    end
                    if (cs_fall) begin
                        align_err <= (bit_cnt != 3'd0);
                        state     <= FLUSH;
                    end
                end
                DROP_HOLD: begin
                    if (bit_event) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) len <= len_inc;
                    end
                    if (cs_fall) state <= FLUSH;
                end
                FLUSH: begin
                    if (!hold_valid || space) begin
                        hold_valid <= 1'b0;
                        st_valid   <= 1'b1;
                        st_len     <= len;
                        st_flags   <= {align_err, overflow,
                                       (len > 11'(MAX_LEN)), (len < 11'(MIN_LEN))};
                        state      <= IDLE;
                    end
                end
                DROP: if (cs_fall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
